// File: rtl/sgpr_ckpt_if.sv
// Bus bundle for the checkpointed register file: read/write ports, copy requests and status.
// Names follow the register-file port list; master drives addresses and requests.
interface sgpr_ckpt_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 16,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0]           raddr_a_i;
    logic [ADDR_WIDTH-1:0]           raddr_b_i;
    logic [DATA_WIDTH-1:0]           rdata_a_o;
    logic [DATA_WIDTH-1:0]           rdata_b_o;
    logic [ADDR_WIDTH-1:0]           waddr_a_i;
    logic [DATA_WIDTH-1:0]           wdata_a_i;
    logic                            we_a_i;
    logic                            ckpt_req_i;
    logic                            rbk_req_i;
    logic                            busy_o;
    logic                            done_o;
    logic [NUM_WORDS*DATA_WIDTH-1:0] rf_reg_o;

    modport master (
        output raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i, ckpt_req_i, rbk_req_i,
        input  rdata_a_o, rdata_b_o, busy_o, done_o, rf_reg_o
    );

    modport slave (
        input  raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i, ckpt_req_i, rbk_req_i,
        output rdata_a_o, rdata_b_o, busy_o, done_o, rf_reg_o
    );
endinterface

// File: rtl/sgpr_ckpt.sv
// Register file with a shadow copy: checkpoint/rollback walk one word per cycle.
// Optional macro SGPR_CKPT_BYPASS_EN forwards same-cycle write data to the read ports.
//
// state  | meaning
// S_IDLE | normal read/write access, accepts copy requests
// S_CKPT | copying working[idx] -> shadow[idx]
// S_RBK  | copying shadow[idx] -> working[idx]
module sgpr_ckpt #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic      clk,
    input  logic      rst,
    sgpr_ckpt_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CKPT, S_RBK} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]   w_idx_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_last;
    logic                    w_wr_hit;
    logic                    w_wr_ok;
    logic [DATA_WIDTH-1:0]   r_work   [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   r_shadow [NUM_WORDS];

    assign w_last = (r_idx == ADDR_WIDTH'(NUM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // rollback has priority when both requests arrive together
                if (bus.rbk_req_i) begin
                    w_state_nxt = S_RBK;
                    w_idx_nxt   = '0;
                end else if (bus.ckpt_req_i) begin
                    w_state_nxt = S_CKPT;
                    w_idx_nxt   = '0;
                end
            end
            S_CKPT, S_RBK: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Address match by comparison keeps out-of-range addresses from hitting any word.
    always_comb begin
        w_wr_hit = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (bus.waddr_a_i == ADDR_WIDTH'(i)) w_wr_hit = 1'b1;
        end
    end

    assign w_wr_ok = bus.we_a_i && (r_state == S_IDLE) && w_wr_hit;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rst) begin
                r_work[i]   <= '0;
                r_shadow[i] <= '0;
            end else begin
                if (r_state == S_RBK && r_idx == ADDR_WIDTH'(i)) begin
                    r_work[i] <= r_shadow[i];
                end else if (w_wr_ok && bus.waddr_a_i == ADDR_WIDTH'(i)) begin
                    r_work[i] <= bus.wdata_a_i;
                end
                if (r_state == S_CKPT && r_idx == ADDR_WIDTH'(i)) begin
                    r_shadow[i] <= r_work[i];
                end
            end
        end
    end

    always_comb begin
        bus.rdata_a_o = '0;
        bus.rdata_b_o = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (bus.raddr_a_i == ADDR_WIDTH'(i)) bus.rdata_a_o = r_work[i];
            if (bus.raddr_b_i == ADDR_WIDTH'(i)) bus.rdata_b_o = r_work[i];
        end
`ifdef SGPR_CKPT_BYPASS_EN
        if (w_wr_ok && bus.raddr_a_i == bus.waddr_a_i) bus.rdata_a_o = bus.wdata_a_i;
        if (w_wr_ok && bus.raddr_b_i == bus.waddr_a_i) bus.rdata_b_o = bus.wdata_a_i;
`endif
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_rf_out
        assign bus.rf_reg_o[g*DATA_WIDTH +: DATA_WIDTH] = r_work[g];
    end

    assign bus.busy_o = (r_state != S_IDLE);
    assign bus.done_o = r_done;

endmodule

// File: doc/sgpr_ckpt.md
SGPR_CKPT -- requirements
Module: sgpr_ckpt

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register word width in bits.
REQ-002 Parameter NUM_WORDS, default 16, SHALL set the register count; legal range 2..2^ADDR_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 5, SHALL set the width of every address port.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 raddr_a_i / raddr_b_i  input  ADDR_WIDTH  SHALL be the read addresses, ports A and B.
REQ-007 rdata_a_o / rdata_b_o  output  DATA_WIDTH  SHALL be the combinational read data, ports A and B.
REQ-008 waddr_a_i  input  ADDR_WIDTH, wdata_a_i  input  DATA_WIDTH, we_a_i  input  1  SHALL form the write port.
REQ-009 ckpt_req_i  input  1  SHALL request a checkpoint (working file copied to shadow file).
REQ-010 rbk_req_i  input  1  SHALL request a rollback (shadow file copied to working file).
REQ-011 busy_o  output  1  SHALL be high while a checkpoint or rollback copy is in progress.
REQ-012 done_o  output  1  SHALL pulse high for one cycle when a copy completes.
REQ-013 rf_reg_o  output  NUM_WORDS*DATA_WIDTH  SHALL expose the working file, word i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-014 FSM states: IDLE, CKPT, RBK; a counter idx (0..NUM_WORDS-1) SHALL select the word being copied.
REQ-015 IDLE with rbk_req_i=1 SHALL go to RBK with idx=0; else with ckpt_req_i=1 SHALL go to CKPT with idx=0; both high: rollback wins.
REQ-016 CKPT SHALL copy working[idx] to shadow[idx], one word per cycle, idx incrementing.
REQ-017 RBK SHALL copy shadow[idx] to working[idx], one word per cycle, idx incrementing.
REQ-018 After copying idx=NUM_WORDS-1, the FSM SHALL return to IDLE; busy_o high for exactly NUM_WORDS cycles, starting the cycle after the request.
REQ-019 done_o SHALL be high in the first IDLE cycle after a copy and low otherwise.
REQ-020 Requests arriving while busy_o=1 SHALL be ignored, not queued.
REQ-021 A write in IDLE SHALL update working[waddr_a_i] at the next edge.
REQ-022 A write in the request cycle SHALL take effect; the following checkpoint SHALL include it.
REQ-023 Writes while busy_o=1 SHALL be dropped; the producer holds we_a_i until busy_o=0.
REQ-024 Reads SHALL always return the current working file, including during rollback (partially restored contents).
REQ-025 Out-of-range addresses (>= NUM_WORDS): reads SHALL return 0 and writes SHALL be ignored.

Reset
REQ-026 rst=1 SHALL clear all working and shadow words to 0, force IDLE, set idx=0, busy_o=0 and done_o=0.
REQ-027 rst asserted mid-copy SHALL abort the copy, with no done_o pulse.

Configuration
REQ-028 Macro SGPR_CKPT_BYPASS_EN defined: a read with raddr equal to waddr_a_i during an accepted write SHALL return wdata_a_i in the same cycle.
REQ-029 Macro SGPR_CKPT_BYPASS_EN undefined: the same read SHALL return the old word; new data is visible the next cycle.

Verification
REQ-030 Reset, then read A=3, B=15 -> rdata_a_o=0, rdata_b_o=0, busy_o=0.
REQ-031 Write 10<-100 then 11<-103; read A=10 -> 100; rf_reg_o word 11 = 103.
REQ-032 Checkpoint after REQ-031 writes, write 10<-7, rollback -> busy_o high 16 cycles each, done_o pulses; afterwards word 10=100.
REQ-033 ckpt_req_i and rbk_req_i together from reset-zero shadow with word 5=55 -> rollback runs, word 5=0.
REQ-034 Write 4<-9 while busy_o=1 -> word 4 unchanged; retried after done_o -> word 4=9.
REQ-035 Read A=12 with write 12<-42 in the same cycle -> 42 with SGPR_CKPT_BYPASS_EN defined, old value without it; rst mid-rollback -> all zero, no done_o.
